idli_ctl_m: RTL and testbench

Sync/control block for the core: it owns the 2-bit slice counter that sequences every 4-bit-slice datapath unit (SQI, EX, UART TX/RX). It synchronises reset release and runs the one-time external memory initialisation handshake with the SQI controller. It gates core execution into RUN/HALT on instruction (slice-counter wrap) boundaries. It is instantiated once in the top level and drives the shared counter in place of the top-level counter.

---
 rtl/idli_pkg.sv | 20 ++
 rtl/idli_rst_sync_m.sv | 24 ++
 rtl/idli_ctl_m.sv | 134 +++++++++++++
 tb/tb_idli_ctl_m.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli core.
//   ctr_t        - 2-bit slice counter; slice 0 is the least significant nibble.
//   ctl_state_t  - state encoding of the sync/control block (idli_ctl_m).
//   CTL_INIT_TIMEOUT_DEFAULT - cycles allowed for external memory init.
package idli_pkg;

    typedef logic [1:0] ctr_t;

    typedef enum logic [2:0] {
        CTL_RST  = 3'd0,
        CTL_INIT = 3'd1,
        CTL_WAIT = 3'd2,
        CTL_RUN  = 3'd3,
        CTL_HALT = 3'd4,
        CTL_ERR  = 3'd5
    } ctl_state_t;

    localparam int CTL_INIT_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/idli_rst_sync_m.sv
// idli_rst_sync_m: 2-flop reset synchroniser, asynchronous assert,
// synchronous deassert.
//   i_clk    - clock the released reset is aligned to
//   i_rst_n  - raw asynchronous active-low reset
//   o_rst_n  - synchronised active-low reset (high two edges after release)
module idli_rst_sync_m (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [1:0] sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign o_rst_n = sync[1];

endmodule

// File: rtl/idli_ctl_m.sv
// idli_ctl_m: sync/control block of the core.
// Owns the shared slice counter, synchronises reset release, runs the
// one-time memory init handshake with SQI and gates RUN/HALT on
// instruction (counter wrap) boundaries.
//   i_ctl_gck           - core clock
//   i_ctl_rst_n         - asynchronous active-low reset
//   o_ctl_rst_n         - synchronised reset for the rest of the core
//   o_ctl_ctr           - slice counter 0..3
//   o_ctl_mem_init      - level request to SQI for its mode-set sequence
//   i_ctl_mem_init_done - one-cycle pulse from SQI, mode-set complete
//   i_ctl_halt          - level halt request
//   o_ctl_run           - core may fetch/execute
//   o_ctl_halted        - high while halted
//   o_ctl_err           - sticky memory init timeout
//   o_ctl_dbg_state     - current FSM state (ctl_state_t encoding)
//
// Handshake: o_ctl_mem_init is held high for the whole INIT state and acts
// as the request; SQI answers with a single-cycle i_ctl_mem_init_done,
// which is only honoured while in INIT. Dropping mem_init is the
// acknowledgement of that pulse.
module idli_ctl_m
    import idli_pkg::*;
#(
    parameter int INIT_TIMEOUT = CTL_INIT_TIMEOUT_DEFAULT
) (
    input  logic       i_ctl_gck,
    input  logic       i_ctl_rst_n,
    output logic       o_ctl_rst_n,
    output ctr_t       o_ctl_ctr,
    output logic       o_ctl_mem_init,
    input  logic       i_ctl_mem_init_done,
    input  logic       i_ctl_halt,
    output logic       o_ctl_run,
    output logic       o_ctl_halted,
    output logic       o_ctl_err,
    output logic [2:0] o_ctl_dbg_state
);

    localparam int TW = $clog2(INIT_TIMEOUT + 1);
    // The INIT cycle that sees this count is the last one allowed.
    localparam logic [TW-1:0] T_LAST = TW'(INIT_TIMEOUT - 1);

    ctl_state_t    state;
    logic [TW-1:0] tcnt;
    logic          rst_sync_n;

    idli_rst_sync_m u_rst_sync (
        .i_clk   (i_ctl_gck),
        .i_rst_n (i_ctl_rst_n),
        .o_rst_n (rst_sync_n)
    );

    assign o_ctl_rst_n     = rst_sync_n;
    assign o_ctl_dbg_state = state;

    // Outputs are registered alongside the state so none of them is
    // combinational from an input. Every wrap edge (ctr == 3) is an
    // instruction boundary, so RUN/HALT are only ever entered there and
    // always start with ctr == 0.
    always_ff @(posedge i_ctl_gck or negedge i_ctl_rst_n) begin
        if (!i_ctl_rst_n) begin
            state          <= CTL_RST;
            o_ctl_ctr      <= 2'd0;
            tcnt           <= '0;
            o_ctl_mem_init <= 1'b0;
            o_ctl_run      <= 1'b0;
            o_ctl_halted   <= 1'b0;
            o_ctl_err      <= 1'b0;
        end else if (!rst_sync_n) begin
            // Reset released but not yet through the synchroniser.
            state          <= CTL_RST;
            o_ctl_ctr      <= 2'd0;
            tcnt           <= '0;
            o_ctl_mem_init <= 1'b0;
            o_ctl_run      <= 1'b0;
            o_ctl_halted   <= 1'b0;
            o_ctl_err      <= 1'b0;
        end else begin
            o_ctl_ctr <= o_ctl_ctr + 2'd1;
            case (state)
                CTL_RST: begin
                    state          <= CTL_INIT;
                    o_ctl_mem_init <= 1'b1;
                    tcnt           <= '0;
                end
                CTL_INIT: begin
                    // Done beats a simultaneous timeout.
                    if (i_ctl_mem_init_done) begin
                        state          <= CTL_WAIT;
                        o_ctl_mem_init <= 1'b0;
                    end else if (tcnt == T_LAST) begin
                        state          <= CTL_ERR;
                        o_ctl_mem_init <= 1'b0;
                        o_ctl_err      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CTL_WAIT: begin
                    if (o_ctl_ctr == 2'd3) begin
                        if (i_ctl_halt) begin
                            state        <= CTL_HALT;
                            o_ctl_halted <= 1'b1;
                        end else begin
                            state     <= CTL_RUN;
                            o_ctl_run <= 1'b1;
                        end
                    end
                end
                CTL_RUN: begin
                    if (o_ctl_ctr == 2'd3 && i_ctl_halt) begin
                        state        <= CTL_HALT;
                        o_ctl_run    <= 1'b0;
                        o_ctl_halted <= 1'b1;
                    end
                end
                CTL_HALT: begin
                    if (o_ctl_ctr == 2'd3 && !i_ctl_halt) begin
                        state        <= CTL_RUN;
                        o_ctl_run    <= 1'b1;
                        o_ctl_halted <= 1'b0;
                    end
                end
                CTL_ERR: begin
                    // Terminal until reset; only the slice counter moves.
                end
                default: begin
                    state <= CTL_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_ctl_m.sv
module tb_idli_ctl_m;
    import idli_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (default timeout)
    logic       rst_n, done, halt;
    logic       ro, mem, run, hlt, err;
    ctr_t       ctr;
    logic [2:0] st;

    // timeout instance (INIT_TIMEOUT = 8)
    logic       rst2_n, done2, halt2;
    logic       ro2, mem2, run2, hlt2, err2;
    ctr_t       ctr2;
    logic [2:0] st2;

    idli_ctl_m dut (
        .i_ctl_gck           (clk),
        .i_ctl_rst_n         (rst_n),
        .o_ctl_rst_n         (ro),
        .o_ctl_ctr           (ctr),
        .o_ctl_mem_init      (mem),
        .i_ctl_mem_init_done (done),
        .i_ctl_halt          (halt),
        .o_ctl_run           (run),
        .o_ctl_halted        (hlt),
        .o_ctl_err           (err),
        .o_ctl_dbg_state     (st)
    );

    idli_ctl_m #(.INIT_TIMEOUT(8)) dut_to (
        .i_ctl_gck           (clk),
        .i_ctl_rst_n         (rst2_n),
        .o_ctl_rst_n         (ro2),
        .o_ctl_ctr           (ctr2),
        .o_ctl_mem_init      (mem2),
        .i_ctl_mem_init_done (done2),
        .i_ctl_halt          (halt2),
        .o_ctl_run           (run2),
        .o_ctl_halted        (hlt2),
        .o_ctl_err           (err2),
        .o_ctl_dbg_state     (st2)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst_n, done, halt;
        logic       ro;
        logic [1:0] ctr;
        logic       mem, run, hlt, err;
        ctl_state_t st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic d, input logic h,
                                input logic e_ro, input logic [1:0] e_ctr,
                                input logic e_mem, input logic e_run,
                                input logic e_hlt, input logic e_err,
                                input ctl_state_t e_st);
        vec_t v;
        v.rst_n = r;  v.done = d;  v.halt = h;
        v.ro = e_ro;  v.ctr = e_ctr; v.mem = e_mem; v.run = e_run;
        v.hlt = e_hlt; v.err = e_err; v.st = e_st;
        return v;
    endfunction

    // Watchdog: the run is linear, this only fires on a broken simulator hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic saw_run;

    initial begin
        rst_n = 1'b0; done = 1'b0; halt = 1'b0;
        rst2_n = 1'b0; done2 = 1'b0; halt2 = 1'b0;
        tick();
        tick();

        // ---------- timeout instance: reset values ----------
        chk("to_rst.ro", 32'(ro2), 0);
        chk("to_rst.ctr", 32'(ctr2), 0);
        chk("to_rst.mem", 32'(mem2), 0);
        chk("to_rst.run", 32'(run2), 0);
        chk("to_rst.err", 32'(err2), 0);
        chk("to_rst.st", 32'(st2), 32'(CTL_RST));

        // ---------- init timeout, done never pulsed ----------
        rst2_n = 1'b1;
        tick();                                   // E1
        chk("to_e1.ro", 32'(ro2), 0);
        tick();                                   // E2
        chk("to_e2.ro", 32'(ro2), 1);
        tick();                                   // E3
        chk("to_e3.mem", 32'(mem2), 1);
        chk("to_e3.ctr", 32'(ctr2), 1);
        chk("to_e3.st", 32'(st2), 32'(CTL_INIT));
        for (int i = 0; i < 7; i++) tick();       // E4..E10
        chk("to_e10.err", 32'(err2), 0);
        chk("to_e10.mem", 32'(mem2), 1);
        tick();                                   // E11: 8th cycle in INIT
        chk("to_e11.err", 32'(err2), 1);
        chk("to_e11.mem", 32'(mem2), 0);
        chk("to_e11.run", 32'(run2), 0);
        chk("to_e11.st", 32'(st2), 32'(CTL_ERR));
        chk("to_e11.ctr", 32'(ctr2), 1);
        done2 = 1'b1;                             // ignored in ERR
        tick();
        done2 = 1'b0;
        chk("to_err.ctr0", 32'(ctr2), 2);
        tick();
        chk("to_err.ctr1", 32'(ctr2), 3);
        tick();
        chk("to_err.ctr2", 32'(ctr2), 0);
        tick();
        chk("to_err.ctr3", 32'(ctr2), 1);
        chk("to_err.err", 32'(err2), 1);
        chk("to_err.run", 32'(run2), 0);
        chk("to_err.st", 32'(st2), 32'(CTL_ERR));

        // ---------- done on the exact timeout cycle ----------
        rst2_n = 1'b0;
        tick();
        rst2_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();      // E1..E10
        done2 = 1'b1;
        tick();                                   // E11
        done2 = 1'b0;
        chk("tie.st", 32'(st2), 32'(CTL_WAIT));
        chk("tie.err", 32'(err2), 0);
        chk("tie.mem", 32'(mem2), 0);
        tick(); tick(); tick();                   // ctr 2,3 then wrap
        chk("tie.run", 32'(run2), 1);
        chk("tie.ctr", 32'(ctr2), 0);

        // ---------- main instance: table-driven sequence ----------
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0, 0,0,0,0,0,0, CTL_RST));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,0, CTL_RST));   // E1
        vecs.push_back(mk(1,0,0, 1,0,0,0,0,0, CTL_RST));   // E2
        vecs.push_back(mk(1,0,0, 1,1,1,0,0,0, CTL_INIT));  // E3
        vecs.push_back(mk(1,0,0, 1,2,1,0,0,0, CTL_INIT));  // E4
        vecs.push_back(mk(1,0,0, 1,3,1,0,0,0, CTL_INIT));
        vecs.push_back(mk(1,0,0, 1,0,1,0,0,0, CTL_INIT));
        vecs.push_back(mk(1,0,0, 1,1,1,0,0,0, CTL_INIT));
        vecs.push_back(mk(1,0,0, 1,2,1,0,0,0, CTL_INIT));
        vecs.push_back(mk(1,0,0, 1,3,1,0,0,0, CTL_INIT));
        vecs.push_back(mk(1,0,0, 1,0,1,0,0,0, CTL_INIT));
        vecs.push_back(mk(1,0,0, 1,1,1,0,0,0, CTL_INIT));
        vecs.push_back(mk(1,0,0, 1,2,1,0,0,0, CTL_INIT));  // E12
        vecs.push_back(mk(1,1,0, 1,3,0,0,0,0, CTL_WAIT));  // E13 done
        vecs.push_back(mk(1,0,0, 1,0,0,1,0,0, CTL_RUN));   // E14 wrap -> RUN
        vecs.push_back(mk(1,0,0, 1,1,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,1, 1,2,0,1,0,0, CTL_RUN));   // halt from ctr 1
        vecs.push_back(mk(1,0,1, 1,3,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,1, 1,0,0,0,1,0, CTL_HALT));  // 3 cycles later
        vecs.push_back(mk(1,0,1, 1,1,0,0,1,0, CTL_HALT));
        vecs.push_back(mk(1,0,1, 1,2,0,0,1,0, CTL_HALT));
        vecs.push_back(mk(1,0,0, 1,3,0,0,1,0, CTL_HALT));  // release at ctr 2
        vecs.push_back(mk(1,0,0, 1,0,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,1,0, 1,1,0,1,0,0, CTL_RUN));   // spurious done
        vecs.push_back(mk(1,0,0, 1,2,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,0, 1,3,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,0, 1,0,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,1, 1,1,0,1,0,0, CTL_RUN));   // 2-cycle halt pulse
        vecs.push_back(mk(1,0,1, 1,2,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,0, 1,3,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,0, 1,0,0,1,0,0, CTL_RUN));   // pulse missed
        vecs.push_back(mk(1,0,1, 1,1,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,1, 1,2,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,1, 1,3,0,1,0,0, CTL_RUN));
        vecs.push_back(mk(1,0,1, 1,0,0,0,1,0, CTL_HALT));
        vecs.push_back(mk(1,1,1, 1,1,0,0,1,0, CTL_HALT));  // spurious done
        vecs.push_back(mk(1,0,1, 1,2,0,0,1,0, CTL_HALT));

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            done  = vecs[i].done;
            halt  = vecs[i].halt;
            tick();
            chk($sformatf("vec%0d.ro", i),  32'(ro),  32'(vecs[i].ro));
            chk($sformatf("vec%0d.ctr", i), 32'(ctr), 32'(vecs[i].ctr));
            chk($sformatf("vec%0d.mem", i), 32'(mem), 32'(vecs[i].mem));
            chk($sformatf("vec%0d.run", i), 32'(run), 32'(vecs[i].run));
            chk($sformatf("vec%0d.hlt", i), 32'(hlt), 32'(vecs[i].hlt));
            chk($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("vec%0d.st", i),  32'(st),  32'(vecs[i].st));
        end
        done = 1'b0;

        // ---------- resume, then reset mid-RUN at ctr == 2 ----------
        halt = 1'b0;
        tick();                                   // ctr 3, still HALT
        tick();                                   // wrap -> RUN
        chk("resume.run", 32'(run), 1);
        chk("resume.ctr", 32'(ctr), 0);
        tick();
        tick();
        chk("mid.ctr_pre", 32'(ctr), 2);
        rst_n = 1'b0;
        #1;
        chk("mid.run", 32'(run), 0);
        chk("mid.ctr", 32'(ctr), 0);
        chk("mid.ro", 32'(ro), 0);
        chk("mid.st", 32'(st), 32'(CTL_RST));
        tick();
        rst_n = 1'b1;

        // ---------- init repeats; halt held through WAIT ----------
        halt = 1'b1;
        saw_run = 1'b0;
        tick();                                   // E1
        chk("re.e1.ro", 32'(ro), 0);
        tick();                                   // E2
        chk("re.e2.ro", 32'(ro), 1);
        tick();                                   // E3
        chk("re.e3.mem", 32'(mem), 1);
        chk("re.e3.ctr", 32'(ctr), 1);
        for (int i = 0; i < 5; i++) begin         // E4..E8
            tick();
            if (run) saw_run = 1'b1;
        end
        done = 1'b1;
        tick();                                   // E9: ctr 3
        done = 1'b0;
        if (run) saw_run = 1'b1;
        chk("wh.st_wait", 32'(st), 32'(CTL_WAIT));
        chk("wh.mem", 32'(mem), 0);
        tick();                                   // E10: wrap -> HALT
        if (run) saw_run = 1'b1;
        chk("wh.st_halt", 32'(st), 32'(CTL_HALT));
        chk("wh.hlt", 32'(hlt), 1);
        chk("wh.ctr", 32'(ctr), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (run) saw_run = 1'b1;
        end
        chk("wh.no_run", 32'(saw_run), 0);
        chk("wh.err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
